// File: rtl/f1_race_sequencer_pkg.sv
// Shared constants, state codes and helpers for the F1 start-light reaction timer.
// All millisecond quantities are CNT_W bits wide so they map straight onto the BCD display path.
package f1_race_sequencer_pkg;

    localparam int CNT_W          = 14;
    localparam int TICKS_PER_STEP = 500;
    localparam int N_STEPS        = 5;
    localparam int HOLD_BASE_MS   = 200;
    localparam int TIMEOUT_MS     = 9999;

    localparam logic [9:0] LED_ALL    = 10'h3FF;
    localparam logic [6:0] LFSR_SEED  = 7'h01;
    localparam logic [6:0] LFSR_TAPS  = 7'h60;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_LIGHTS = 3'd1;
    localparam state_t ST_HOLD   = 3'd2;
    localparam state_t ST_GO     = 3'd3;
    localparam state_t ST_SHOW   = 3'd4;
    localparam state_t ST_FAULT  = 3'd5;

    // x^7 + x^6 + 1 Fibonacci step; the feedback is the XOR of bits 6 and 5.
    function automatic logic [6:0] lfsr_next(input logic [6:0] v);
        return {v[5:0], ^(v & LFSR_TAPS)};
    endfunction

    // Light pattern with k pairs lit, filling from ledr[9:8] downwards.
    function automatic logic [9:0] led_mask(input logic [2:0] k);
        return LED_ALL & ~(LED_ALL >> {k, 1'b0});
    endfunction

endpackage

// File: rtl/f1_race_sequencer_if.sv
// Button/tick inputs and display/status outputs of the race sequencer, plus its FSM state.
// There is no handshake: tick_ms/trigger/react are levels sampled every clk, result_valid is a 1-cycle strobe.
interface f1_race_sequencer_if;
    import f1_race_sequencer_pkg::*;

    logic             tick_ms;
    logic             trigger;
    logic             react;
    logic [9:0]       ledr;
    logic [CNT_W-1:0] reaction_ms;
    logic             result_valid;
    logic             timeout;
    logic             jump_start;
    logic [CNT_W-1:0] best_ms;
    state_t           state;

    modport master (
        output tick_ms, trigger, react,
        input  ledr, reaction_ms, result_valid, timeout, jump_start, best_ms, state
    );

    modport slave (
        input  tick_ms, trigger, react,
        output ledr, reaction_ms, result_valid, timeout, jump_start, best_ms, state
    );

endinterface

// File: rtl/f1_race_sequencer_lfsr7.sv
// 7-bit maximal-length LFSR that randomises the all-lit hold time; never reaches zero.
module lfsr7
    import f1_race_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [6:0] q
);

    logic [6:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= LFSR_SEED;
        end else if (en) begin
            r_q <= lfsr_next(r_q);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/f1_race_sequencer.sv
// F1 start sequence: lights five pairs, holds a pseudo-random time, blacks out and
// times the driver's button in ms; flags jump starts and keeps the best valid time.
module f1_race_sequencer
    import f1_race_sequencer_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    f1_race_sequencer_if.slave bus
);

    state_t           r_state;
    logic             r_trig_d;
    logic             r_react_d;
    logic [CNT_W-1:0] r_timer;
    logic [2:0]       r_step;
    logic [CNT_W-1:0] r_hold;
    logic [CNT_W-1:0] r_count;
    logic [9:0]       r_ledr;
    logic [CNT_W-1:0] r_reaction;
    logic             r_valid;
    logic             r_timeout;
    logic             r_jump;
    logic [CNT_W-1:0] r_best;

    logic             w_trig_edge;
    logic             w_react_edge;
    logic             w_lfsr_en;
    logic [6:0]       w_lfsr;
    logic [CNT_W-1:0] w_hold_ms;

    // Delay regs reset high so a button already held at reset release is not an edge.
    assign w_trig_edge  = bus.trigger & ~r_trig_d;
    assign w_react_edge = bus.react & ~r_react_d;
    assign w_lfsr_en    = bus.tick_ms &
                          ((r_state == ST_IDLE) || (r_state == ST_SHOW) || (r_state == ST_FAULT));
    assign w_hold_ms    = CNT_W'(HOLD_BASE_MS) + CNT_W'({w_lfsr, 3'b000});

    lfsr7 u_lfsr (
        .clk (clk),
        .rst (rst),
        .en  (w_lfsr_en),
        .q   (w_lfsr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_trig_d   <= 1'b1;
            r_react_d  <= 1'b1;
            r_timer    <= '0;
            r_step     <= '0;
            r_hold     <= '0;
            r_count    <= '0;
            r_ledr     <= '0;
            r_reaction <= '0;
            r_valid    <= 1'b0;
            r_timeout  <= 1'b0;
            r_jump     <= 1'b0;
            r_best     <= CNT_W'(TIMEOUT_MS);
        end else begin
            r_trig_d  <= bus.trigger;
            r_react_d <= bus.react;
            r_valid   <= 1'b0;
            case (r_state)
                ST_IDLE, ST_SHOW, ST_FAULT: begin
                    if (w_trig_edge) begin
                        r_state <= ST_LIGHTS;
                        r_step  <= '0;
                        r_timer <= '0;
                        r_jump  <= 1'b0;
                        r_ledr  <= '0;
                    end
                end
                ST_LIGHTS: begin
                    if (w_react_edge) begin
                        r_state <= ST_FAULT;
                        r_jump  <= 1'b1;
                        r_ledr  <= LED_ALL;
                    end else if (bus.tick_ms) begin
                        if (r_timer == CNT_W'(TICKS_PER_STEP - 1)) begin
                            r_timer <= '0;
                            r_step  <= r_step + 3'd1;
                            r_ledr  <= led_mask(r_step + 3'd1);
                            if (r_step + 3'd1 == 3'(N_STEPS)) begin
                                r_state <= ST_HOLD;
                                r_hold  <= w_hold_ms;
                            end
                        end else begin
                            r_timer <= r_timer + CNT_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (w_react_edge) begin
                        r_state <= ST_FAULT;
                        r_jump  <= 1'b1;
                        r_ledr  <= LED_ALL;
                    end else if (bus.tick_ms) begin
                        if (r_timer == r_hold - CNT_W'(1)) begin
                            r_state <= ST_GO;
                            r_ledr  <= '0;
                            r_count <= '0;
                        end else begin
                            r_timer <= r_timer + CNT_W'(1);
                        end
                    end
                end
                ST_GO: begin
                    // A press wins over a coincident tick, so the pre-increment count is latched.
                    if (w_react_edge) begin
                        r_state    <= ST_SHOW;
                        r_reaction <= r_count;
                        r_timeout  <= 1'b0;
                        r_valid    <= 1'b1;
                        if (r_count < r_best) begin
                            r_best <= r_count;
                        end
                    end else if (bus.tick_ms) begin
                        if (r_count == CNT_W'(TIMEOUT_MS - 1)) begin
                            r_state    <= ST_SHOW;
                            r_count    <= CNT_W'(TIMEOUT_MS);
                            r_reaction <= CNT_W'(TIMEOUT_MS);
                            r_timeout  <= 1'b1;
                            r_valid    <= 1'b1;
                        end else begin
                            r_count <= r_count + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ledr  <= '0;
                end
            endcase
        end
    end

    assign bus.ledr         = r_ledr;
    assign bus.reaction_ms  = r_reaction;
    assign bus.result_valid = r_valid;
    assign bus.timeout      = r_timeout;
    assign bus.jump_start   = r_jump;
    assign bus.best_ms      = r_best;
    assign bus.state        = r_state;

endmodule

// File: tb/tb_f1_race_sequencer.sv
// Randomised bench for f1_race_sequencer: a ms-level race model predicts results into a
// queue that a negedge monitor pops on every result_valid strobe.
module tb_f1_race_sequencer;
    import f1_race_sequencer_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    f1_race_sequencer_if bus();

    f1_race_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // {timeout, reaction_ms, best_ms}
    logic [28:0] exp_q[$];
    logic [28:0] mon_e;

    logic [6:0] m_lfsr;
    int         m_best;
    int         m_last;
    bit         m_free;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [9:0] lit(input int k);
        logic [9:0] v;
        v = '0;
        for (int i = 0; i < 2 * k; i++) v[9 - i] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        m_lfsr = 7'h01;
        m_best = TIMEOUT_MS;
        m_last = 0;
        m_free = 1'b1;
    endtask

    // One clock; the random source advances on every tick while no race is in progress.
    task automatic cyc(input bit t);
        bus.tick_ms = t;
        @(posedge clk);
        if (t && m_free) m_lfsr = {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
        #1;
        bus.tick_ms = 1'b0;
    endtask

    task automatic ticks(input int n, input int max_gap);
        for (int i = 0; i < n; i++) begin
            cyc(1'b1);
            repeat ($urandom_range(0, max_gap)) cyc(1'b0);
        end
    endtask

    task automatic pulse_trigger();
        bus.trigger = 1'b1;
        cyc(1'b0);
        bus.trigger = 1'b0;
    endtask

    task automatic race(input int react_ms, input bit to, input bit trig_hold,
                        input bit with_tick, input bit pre_trig, input int gap);
        int hold;
        if (!pre_trig) begin
            pulse_trigger();
            m_free = 1'b0;
            check("lights_start", 32'(bus.state), 32'(ST_LIGHTS));
        end
        hold = HOLD_BASE_MS + 8 * int'(m_lfsr);
        for (int k = 1; k <= N_STEPS; k++) begin
            ticks(TICKS_PER_STEP, gap);
            check("ledr_step", 32'(bus.ledr), 32'(lit(k)));
        end
        check("hold_state", 32'(bus.state), 32'(ST_HOLD));
        ticks(hold - 1, gap);
        check("hold_lit", 32'(bus.ledr), 32'h3FF);
        if (trig_hold) begin
            pulse_trigger();
            cyc(1'b0);
            check("trig_in_hold_state", 32'(bus.state), 32'(ST_HOLD));
            check("trig_in_hold_ledr", 32'(bus.ledr), 32'h3FF);
        end
        cyc(1'b1);
        check("lights_out", 32'(bus.ledr), 32'h0);
        check("go_state", 32'(bus.state), 32'(ST_GO));
        if (to) begin
            exp_q.push_back({1'b1, 14'(TIMEOUT_MS), 14'(m_best)});
            m_last = TIMEOUT_MS;
            ticks(TIMEOUT_MS, 0);
        end else begin
            ticks(react_ms, gap);
            if (react_ms < m_best) m_best = react_ms;
            m_last = react_ms;
            exp_q.push_back({1'b0, 14'(react_ms), 14'(m_best)});
            bus.react = 1'b1;
            cyc(with_tick);
            bus.react = 1'b0;
        end
        m_free = 1'b1;
        repeat (3) cyc(1'b0);
        check("show_state", 32'(bus.state), 32'(ST_SHOW));
        check("q_drained", 32'(exp_q.size()), 32'h0);
    endtask

    task automatic fault_run(input int at_ms, input int gap);
        pulse_trigger();
        m_free = 1'b0;
        ticks(at_ms, gap);
        check("pre_fault_ledr", 32'(bus.ledr), 32'(lit(at_ms / TICKS_PER_STEP)));
        bus.react = 1'b1;
        cyc(1'b0);
        m_free = 1'b1;
        check("fault_state", 32'(bus.state), 32'(ST_FAULT));
        check("fault_jump", 32'(bus.jump_start), 32'h1);
        check("fault_ledr", 32'(bus.ledr), 32'h3FF);
        check("fault_reaction_kept", 32'(bus.reaction_ms), 32'(m_last));
        check("fault_no_valid", 32'(bus.result_valid), 32'h0);
        ticks($urandom_range(1, 30), gap);
        bus.react = 1'b0;
        cyc(1'b0);
        check("fault_jump_held", 32'(bus.jump_start), 32'h1);
        pulse_trigger();
        m_free = 1'b0;
        check("restart_jump_clr", 32'(bus.jump_start), 32'h0);
        check("restart_state", 32'(bus.state), 32'(ST_LIGHTS));
        check("restart_ledr", 32'(bus.ledr), 32'h0);
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0 && bus.result_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 32'h1, 32'h0);
            end else begin
                mon_e = exp_q.pop_front();
                check("reaction_ms", 32'(bus.reaction_ms), 32'(mon_e[27:14]));
                check("timeout", 32'(bus.timeout), 32'(mon_e[28]));
                check("best_ms", 32'(bus.best_ms), 32'(mon_e[13:0]));
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.tick_ms = 1'b0;
        bus.trigger = 1'b0;
        bus.react   = 1'b0;
        rst = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ledr", 32'(bus.ledr), 32'h0);
        check("rst_reaction", 32'(bus.reaction_ms), 32'h0);
        check("rst_valid", 32'(bus.result_valid), 32'h0);
        check("rst_timeout", 32'(bus.timeout), 32'h0);
        check("rst_jump", 32'(bus.jump_start), 32'h0);
        check("rst_best", 32'(bus.best_ms), 32'(TIMEOUT_MS));
        check("rst_state", 32'(bus.state), 32'(ST_IDLE));
        rst = 1'b0;
        @(posedge clk);
        #1;

        ticks($urandom_range(0, 40), 1);
        race(150, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        ticks($urandom_range(0, 40), 1);
        race(320, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        ticks($urandom_range(0, 40), 1);
        fault_run(1200, 1);
        race($urandom_range(400, 900), 1'b0, 1'b0, 1'b0, 1'b1, 1);
        ticks($urandom_range(0, 40), 1);
        race(0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        check("timeout_flag", 32'(bus.timeout), 32'h1);
        check("timeout_best_kept", 32'(bus.best_ms), 32'd150);
        ticks($urandom_range(0, 40), 1);
        race(42, 1'b0, 1'b1, 1'b1, 1'b0, 1);

        // Reset in the middle of GO, with trigger held high through release.
        ticks($urandom_range(0, 40), 1);
        pulse_trigger();
        m_free = 1'b0;
        ticks(N_STEPS * TICKS_PER_STEP + HOLD_BASE_MS + 8 * int'(m_lfsr) + 30, 0);
        check("pre_reset_go", 32'(bus.state), 32'(ST_GO));
        #2;
        rst = 1'b1;
        bus.trigger = 1'b1;
        model_reset();
        @(negedge clk);
        check("midgo_rst_ledr", 32'(bus.ledr), 32'h0);
        check("midgo_rst_best", 32'(bus.best_ms), 32'(TIMEOUT_MS));
        check("midgo_rst_state", 32'(bus.state), 32'(ST_IDLE));
        check("midgo_rst_valid", 32'(bus.result_valid), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        repeat (3) cyc(1'b0);
        check("held_trigger_no_edge", 32'(bus.state), 32'(ST_IDLE));
        bus.trigger = 1'b0;
        cyc(1'b0);

        for (int r = 0; r < 2; r++) begin
            ticks($urandom_range(0, 60), 1);
            race($urandom_range(1, 2000), 1'b0, 1'b0, 1'b0, 1'b0, 1);
        end
        check("final_q_empty", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
